// File: rtl/mem_pkg.sv
// Shared constants for the memory-stage SRAM controller: FSM encoding and
// default memory-map parameters.
package mem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
    localparam int          SRAM_AW_DEF   = 18;

endpackage

// File: rtl/sram_phase_counter.sv
// Wait-state counter for one half-word SRAM phase. Loading clears it to zero;
// tc flags the last clock of a phase.
module sram_phase_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + 4'd1;
        end
    end

    assign tc = (count == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage controller: splits each 32-bit load/store into two 16-bit
// asynchronous SRAM phases and freezes the pipeline while the access runs.
module mem_stage_sram_ctrl
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
    parameter int          WAIT_CYCLES = 2,
    parameter int          SRAM_AW     = SRAM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               memReadEn,
    input  logic               memWriteEn,
    input  logic [31:0]        aluResult,
    input  logic [31:0]        valRm,
    output logic [31:0]        readData,
    output logic               ready,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    inout  wire  [15:0]        SRAM_DQ,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N
);

    logic [1:0]         state;
    logic               is_write;
    logic [SRAM_AW-2:0] word_q;
    logic [31:0]        wdata_q;
    logic [31:0]        offset;
    logic               req;
    logic               active;
    logic               tc;

    assign req    = memReadEn | memWriteEn;
    assign active = (state == ST_LOW) || (state == ST_HIGH);
    assign offset = (aluResult - BASE_ADDR) >> 2;

    // Counter is held at zero outside the data phases and re-armed at each phase end.
    sram_phase_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_phase_cnt (
        .clk (clk),
        .rst (rst),
        .load(!active || tc),
        .en  (active),
        .tc  (tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            is_write <= 1'b0;
            word_q   <= '0;
            wdata_q  <= '0;
            readData <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state    <= ST_LOW;
                        is_write <= memWriteEn;
                        word_q   <= offset[SRAM_AW-2:0];
                        wdata_q  <= valRm;
                    end
                end
                ST_LOW: begin
                    if (tc) begin
                        state <= ST_HIGH;
                        if (!is_write) readData[15:0] <= SRAM_DQ;
                    end
                end
                ST_HIGH: begin
                    if (tc) begin
                        state <= ST_DONE;
                        if (!is_write) readData[31:16] <= SRAM_DQ;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Freeze asserts combinationally so the request cycle itself is held.
    assign ready = (state == ST_IDLE) ? !req : (state == ST_DONE);

    // WE_N rises on the last count so address and data are held past the strobe.
    assign SRAM_WE_N = !(active && is_write && !tc);
    assign SRAM_OE_N = !(active && !is_write);
    assign SRAM_ADDR = active ? {word_q, (state == ST_HIGH)} : '0;
    assign SRAM_DQ   = (active && is_write) ?
                       ((state == ST_HIGH) ? wdata_q[31:16] : wdata_q[15:0]) : 16'hzzzz;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: vector table run through a scoreboard against
// a behavioural SRAM, plus reset, idle and long-wait-state sequences.
module tb_mem_stage_sram_ctrl;

    typedef struct {
        logic        re;
        logic        we;
        logic [31:0] alu;
        logic [31:0] val;
        int          rdy_low;
        int          we_low;
        int          oe_low;
        logic [17:0] addr_lo;
        logic [31:0] rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        memReadEn, memWriteEn;
    logic [31:0] aluResult, valRm;
    logic [31:0] readData;
    logic        ready;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        we_n, oe_n;

    logic        re4, we4;
    logic [31:0] alu4, val4;
    logic [31:0] readData4;
    logic        ready4;
    logic [17:0] sram_addr4;
    wire  [15:0] sram_dq4;
    logic        we_n4, oe_n4;

    logic [15:0] mem [0:63];
    vec_t        exp_q[$];
    vec_t        vecs[8];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_stage_sram_ctrl #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .memReadEn(memReadEn), .memWriteEn(memWriteEn),
        .aluResult(aluResult), .valRm(valRm), .readData(readData), .ready(ready),
        .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n)
    );

    mem_stage_sram_ctrl #(.WAIT_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .memReadEn(re4), .memWriteEn(we4),
        .aluResult(alu4), .valRm(val4), .readData(readData4), .ready(ready4),
        .SRAM_ADDR(sram_addr4), .SRAM_DQ(sram_dq4), .SRAM_WE_N(we_n4), .SRAM_OE_N(oe_n4)
    );

    // Behavioural asynchronous SRAM: drives only while output-enabled.
    assign sram_dq = (!oe_n && we_n) ? mem[sram_addr[5:0]] : 16'hzzzz;
    always @(posedge clk) if (!we_n) mem[sram_addr[5:0]] <= sram_dq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_access(input vec_t v, output int cycles);
        int   rl, wl, ol, bad;
        bit   done;
        vec_t e;
        rl = 0; wl = 0; ol = 0; bad = 0; done = 0; cycles = 0;
        @(negedge clk);
        memReadEn = v.re; memWriteEn = v.we; aluResult = v.alu; valRm = v.val;
        exp_q.push_back(v);
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            cycles++;
            if (!ready) begin
                rl++;
                if (!we_n) wl++;
                if (!oe_n) ol++;
                if (!we_n || !oe_n) begin
                    if (sram_addr != v.addr_lo && sram_addr != 18'(v.addr_lo + 18'd1)) bad++;
                    else if (!we_n && sram_dq !== (sram_addr[0] ? v.val[31:16] : v.val[15:0])) bad++;
                end
            end else if (rl > 0) begin
                done = 1;
            end
            if (!done) @(negedge clk);
        end
        e = exp_q.pop_front();
        chk("done_reached", 32'(done), 32'd1);
        chk("ready_low_cycles", 32'(rl), 32'(e.rdy_low));
        chk("we_low_cycles", 32'(wl), 32'(e.we_low));
        chk("oe_low_cycles", 32'(ol), 32'(e.oe_low));
        chk("addr_dq_errors", 32'(bad), 32'd0);
        chk("readData", readData, e.rdata);
    endtask

    initial begin
        int cyc;
        int rl, wl, bad;

        vecs[0] = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 5, 2, 0, 18'd4,  32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'd1032, 32'h0,       5, 0, 4, 18'd4,  32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 32'd1024, 32'h12345678, 5, 2, 0, 18'd0, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b0, 32'd1024, 32'h0,       5, 0, 4, 18'd0,  32'h12345678};
        vecs[4] = '{1'b0, 1'b1, 32'd1043, 32'hCAFEF00D, 5, 2, 0, 18'd8, 32'h12345678};
        vecs[5] = '{1'b1, 1'b0, 32'd1040, 32'h0,       5, 0, 4, 18'd8,  32'hCAFEF00D};
        vecs[6] = '{1'b1, 1'b1, 32'd1048, 32'h00010002, 5, 2, 0, 18'd12, 32'hCAFEF00D};
        vecs[7] = '{1'b1, 1'b0, 32'd1048, 32'h0,       5, 0, 4, 18'd12, 32'h00010002};

        for (int i = 0; i < 64; i++) mem[i] = 16'h0;
        rst = 1'b0;
        memReadEn = 0; memWriteEn = 0; aluResult = 0; valRm = 0;
        re4 = 0; we4 = 0; alu4 = 0; val4 = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_we_n", 32'(we_n), 32'd1);
        chk("reset_oe_n", 32'(oe_n), 32'd1);
        chk("reset_addr", 32'(sram_addr), 32'd0);
        chk("reset_readData", readData, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Back-to-back table: each access must take exactly 2*WAIT_CYCLES+2 cycles.
        for (int i = 0; i < 8; i++) begin
            run_access(vecs[i], cyc);
            chk("access_cycles", 32'(cyc), 32'd6);
        end

        @(negedge clk);
        memReadEn = 0; memWriteEn = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("idle_ready", 32'(ready), 32'd1);
            chk("idle_strobes", 32'({we_n, oe_n}), 32'd3);
            chk("idle_readData", readData, 32'h00010002);
            @(negedge clk);
        end

        // Long wait states, both enables high: a write with 3-of-4 WE_N low per phase.
        re4 = 1; we4 = 1; alu4 = 32'd1044; val4 = 32'h00010002;
        rl = 0; wl = 0; bad = 0;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (!ready4) begin
                rl++;
                if (!we_n4) begin
                    wl++;
                    if (sram_addr4 == 18'd10) begin
                        if (sram_dq4 !== 16'h0002) bad++;
                    end else if (sram_addr4 == 18'd11) begin
                        if (sram_dq4 !== 16'h0001) bad++;
                    end else bad++;
                end
                if (!oe_n4) bad++;
            end else if (rl > 0) break;
            @(negedge clk);
        end
        chk("w4_ready_low", 32'(rl), 32'd9);
        chk("w4_we_low", 32'(wl), 32'd6);
        chk("w4_addr_dq_errors", 32'(bad), 32'd0);
        chk("w4_readData_held", readData4, 32'd0);
        @(negedge clk);
        re4 = 0; we4 = 0;

        // Reset in the middle of a write's LOW phase aborts it before any strobe edge.
        memWriteEn = 1; aluResult = 32'd1032; valRm = 32'h0;
        @(negedge clk);
        #1;
        chk("mid_low_we_n", 32'(we_n), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_we_n", 32'(we_n), 32'd1);
        chk("abort_oe_n", 32'(oe_n), 32'd1);
        chk("abort_addr", 32'(sram_addr), 32'd0);
        chk("abort_ready", 32'(ready), 32'd0);
        chk("abort_readData", readData, 32'd0);
        memWriteEn = 0;
        #1;
        chk("abort_ready_noreq", 32'(ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        run_access(vecs[1], cyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
